// File: rtl/flag_fifo.sv
// flag_fifo -- first-word-fall-through FIFO that sits between the UART
// rx/tx blocks and the bus register interface. It replaces the old
// single-word flag buffer with a DEPTH-entry buffer.
//
// Parameters:
//   WORD_WIDTH  data word width in bits
//   DEPTH       number of entries (power of two, >= 2)
//   OVERWRITE   0: drop a push that finds the FIFO full
//               1: overwrite the oldest word on a full push
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_wr_en, i_din   push strobe and data
//   i_rd_en          pop strobe (removes the head word)
//   i_err_clear      clears both sticky error flags
//   o_dout           head word (mem[rd_ptr])
//   o_flag           FIFO not empty
//   o_full           FIFO holds DEPTH words
//   o_count          occupancy, 0..DEPTH
//   o_overflow_err   sticky: a push found the FIFO full (and no pop with it)
//   o_underflow_err  sticky: a pop found the FIFO empty
//
// Every output is a register or a decode of registers, so there is no
// combinational path from any input to any output.
module flag_fifo #(
  parameter int WORD_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int OVERWRITE  = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_en,
  input  logic [WORD_WIDTH-1:0]  i_din,
  input  logic                   i_rd_en,
  input  logic                   i_err_clear,
  output logic [WORD_WIDTH-1:0]  o_dout,
  output logic                   o_flag,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow_err,
  output logic                   o_underflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam bit OW    = (OVERWRITE != 0);

  // Elaboration-time parameter check.
  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("flag_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [WORD_WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic                  ovf_reg, ovf_next;
  logic                  unf_reg, unf_next;

  logic empty;
  logic full;
  logic do_write;
  logic rd_adv;
  logic ovf_event;
  logic unf_event;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));

  // A push is written unless the FIFO is full with no simultaneous pop and
  // the drop policy is selected.
  assign do_write = i_wr_en && (!full || i_rd_en || OW);

  // The read pointer advances on a real pop, and also on an overwriting
  // push so that the head moves past the word that was just replaced.
  assign rd_adv = (i_rd_en && !empty) || (i_wr_en && !i_rd_en && full && OW);

  // A push together with a pop on a full FIFO is a plain exchange, not an
  // overflow.
  assign ovf_event = i_wr_en && !i_rd_en && full;
  assign unf_event = i_rd_en && empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_write) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (rd_adv) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    if (do_write && !rd_adv) begin
      count_next = count_reg + 1'b1;
    end else if (rd_adv && !do_write) begin
      count_next = count_reg - 1'b1;
    end
    // Setting an error wins over clearing it in the same cycle.
    ovf_next = ovf_event || (ovf_reg && !i_err_clear);
    unf_next = unf_event || (unf_reg && !i_err_clear);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
      unf_reg    <= unf_next;
    end
  end

  // Storage words are individual reset registers so the head reads 0 after
  // reset; popped words are left in place.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          mem_reg[gi] <= '0;
        end else if (do_write && (wr_ptr_reg == PTR_W'(gi))) begin
          mem_reg[gi] <= i_din;
        end
      end
    end
  endgenerate

  assign o_dout          = mem_reg[rd_ptr_reg];
  assign o_flag          = !empty;
  assign o_full          = full;
  assign o_count         = count_reg;
  assign o_overflow_err  = ovf_reg;
  assign o_underflow_err = unf_reg;

endmodule

// File: tb/tb_flag_fifo.sv
// Directed bench for flag_fifo. Two instances share the same stimulus:
// dut_a uses the drop policy and dut_b the overwrite policy.
module tb_flag_fifo;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] din;
  logic       rd_en;
  logic       err_clear;

  logic [7:0] a_dout, b_dout;
  logic       a_flag, b_flag, a_full, b_full;
  logic [2:0] a_count, b_count;
  logic       a_ovf, b_ovf, a_unf, b_unf;

  int checks_total;
  int checks_passed;

  flag_fifo #(.WORD_WIDTH(8), .DEPTH(4), .OVERWRITE(0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_din(din),
    .i_rd_en(rd_en), .i_err_clear(err_clear), .o_dout(a_dout),
    .o_flag(a_flag), .o_full(a_full), .o_count(a_count),
    .o_overflow_err(a_ovf), .o_underflow_err(a_unf)
  );

  flag_fifo #(.WORD_WIDTH(8), .DEPTH(4), .OVERWRITE(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_din(din),
    .i_rd_en(rd_en), .i_err_clear(err_clear), .o_dout(b_dout),
    .o_flag(b_flag), .o_full(b_full), .o_count(b_count),
    .o_overflow_err(b_ovf), .o_underflow_err(b_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic cycle(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    wr_en = wr; din = d; rd_en = rd; err_clear = clr;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; err_clear = 1'b0;
    $display("txn wr=%0b din=%02h rd=%0b clr=%0b | a: cnt=%0d dout=%02h ovf=%0b unf=%0b | b: cnt=%0d dout=%02h ovf=%0b unf=%0b",
             wr, d, rd, clr, a_count, a_dout, a_ovf, a_unf, b_count, b_dout, b_ovf, b_unf);
  endtask

  initial begin
    logic [7:0] exp_a [4];
    logic [7:0] exp_b [4];
    checks_total  = 0;
    checks_passed = 0;
    rst_n = 1'b0; wr_en = 1'b0; din = 8'h00; rd_en = 1'b0; err_clear = 1'b0;

    // Reset state
    #12;
    chk("rst_count", a_count, 0);
    chk("rst_flag", a_flag, 0);
    chk("rst_full", a_full, 0);
    chk("rst_dout", a_dout, 0);
    chk("rst_errs", {a_ovf, a_unf}, 0);
    chk("rst_b_dout", b_dout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic FWFT ordering
    cycle(1, 8'hA1, 0, 0);
    chk("fwft_first_dout", a_dout, 8'hA1);
    chk("fwft_first_flag", a_flag, 1);
    cycle(1, 8'hB2, 0, 0);
    cycle(1, 8'hC3, 0, 0);
    chk("fwft_count3", a_count, 3);
    chk("fwft_flag", a_flag, 1);
    chk("fwft_head", a_dout, 8'hA1);
    exp_a[0] = 8'hA1; exp_a[1] = 8'hB2; exp_a[2] = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fwft_pop%0d", i), a_dout, exp_a[i]);
      cycle(0, 8'h00, 1, 0);
    end
    chk("fwft_empty_flag", a_flag, 0);
    chk("fwft_empty_count", a_count, 0);

    // Fill, then one extra push: drop (a) versus overwrite (b)
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h10 + i), 0, 0);
    chk("fill_full", a_full, 1);
    chk("fill_ovf_clean", a_ovf, 0);
    cycle(1, 8'h14, 0, 0);
    chk("drop_full", a_full, 1);
    chk("drop_ovf", a_ovf, 1);
    chk("drop_count", a_count, 4);
    chk("drop_dout", a_dout, 8'h10);
    chk("ow_ovf", b_ovf, 1);
    chk("ow_count", b_count, 4);
    chk("ow_dout", b_dout, 8'h11);
    exp_a[0] = 8'h10; exp_a[1] = 8'h11; exp_a[2] = 8'h12; exp_a[3] = 8'h13;
    exp_b[0] = 8'h11; exp_b[1] = 8'h12; exp_b[2] = 8'h13; exp_b[3] = 8'h14;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drop_drain%0d", i), a_dout, exp_a[i]);
      chk($sformatf("ow_drain%0d", i), b_dout, exp_b[i]);
      cycle(0, 8'h00, 1, 0);
    end
    chk("drain_a_empty", a_flag, 0);
    chk("drain_b_empty", b_flag, 0);

    // Lone clear of the overflow flag
    cycle(0, 8'h00, 0, 1);
    chk("clr_ovf", a_ovf, 0);

    // Simultaneous push/pop on a full FIFO is an exchange
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h20 + i), 0, 0);
    cycle(1, 8'h55, 1, 0);
    chk("xchg_ovf", a_ovf, 0);
    chk("xchg_count", a_count, 4);
    chk("xchg_dout", a_dout, 8'h21);
    chk("xchg_b_ovf", b_ovf, 0);
    chk("xchg_b_dout", b_dout, 8'h21);
    exp_a[0] = 8'h21; exp_a[1] = 8'h22; exp_a[2] = 8'h23; exp_a[3] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("xchg_drain%0d", i), a_dout, exp_a[i]);
      cycle(0, 8'h00, 1, 0);
    end

    // Push and pop on an empty FIFO: push wins, pop flags underflow
    chk("pre_unf", a_unf, 0);
    cycle(1, 8'h66, 1, 0);
    chk("empty_pp_count", a_count, 1);
    chk("empty_pp_dout", a_dout, 8'h66);
    chk("empty_pp_unf", a_unf, 1);
    cycle(0, 8'h00, 1, 0);
    chk("empty_pp_drained", a_count, 0);

    // Clear racing a new overflow: set wins for overflow only
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h30 + i), 0, 0);
    cycle(1, 8'h77, 0, 0);
    chk("both_set_ovf", a_ovf, 1);
    chk("both_set_unf", a_unf, 1);
    cycle(1, 8'h78, 0, 1);
    chk("race_ovf_stays", a_ovf, 1);
    chk("race_unf_cleared", a_unf, 0);
    cycle(0, 8'h00, 0, 1);
    chk("lone_clr_ovf", a_ovf, 0);
    chk("lone_clr_unf", a_unf, 0);
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0);
    chk("pre_wrap_count", a_count, 0);

    // Wrap-around: 3*DEPTH push-then-pop pairs
    for (int i = 0; i < 12; i++) begin
      cycle(1, 8'(8'h80 + i), 0, 0);
      chk($sformatf("wrap_dout%0d", i), a_dout, 8'(8'h80 + i));
      chk($sformatf("wrap_cnt1_%0d", i), a_count, 1);
      cycle(0, 8'h00, 1, 0);
      chk($sformatf("wrap_cnt0_%0d", i), a_count, 0);
    end
    chk("wrap_no_unf", a_unf, 0);

    // Asynchronous reset mid-stream, checked before the next clock edge
    cycle(1, 8'h9A, 0, 0);
    cycle(1, 8'h9B, 0, 0);
    chk("pre_arst_count", a_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", a_count, 0);
    chk("arst_flag", a_flag, 0);
    chk("arst_full", a_full, 0);
    chk("arst_dout", a_dout, 0);
    chk("arst_errs", {a_ovf, a_unf}, 0);
    chk("arst_b_count", b_count, 0);
    chk("arst_b_dout", b_dout, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
